// File: rtl/iir_out_requant.sv
// Output requantiser for the IIR section: decimate, round half-up, saturate to
// OUT_W, and buffer in a first-word-fall-through FIFO with sticky saturation stats.
module iir_out_requant #(
   parameter int IN_W       = 36,
   parameter int IN_FRAC    = 27,
   parameter int OUT_W      = 16,
   parameter int OUT_FRAC   = 14,
   parameter int DECIM      = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          in_valid,
   input  logic signed [IN_W-1:0]        In1,
   input  logic                          out_ready,
   output logic                          out_valid,
   output logic signed [OUT_W-1:0]       Out1,
   input  logic                          clr_stat,
   output logic                          sat_flag,
   output logic [15:0]                   sat_count,
   output logic                          drop_pulse,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int SHIFT = IN_FRAC - OUT_FRAC;
   localparam int R_W   = IN_W + 1 - SHIFT;
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int CW    = (DECIM > 1) ? $clog2(DECIM) : 1;

   localparam logic [CW-1:0] DCNT_MAX = CW'(DECIM - 1);
   localparam logic [IN_W:0] RND      = (IN_W + 1)'(1) << (SHIFT - 1);
   localparam logic [AW:0]   FULL_LVL = (AW + 1)'(FIFO_DEPTH);

   // ---------------- stage 0: decimation ----------------
   logic [CW-1:0] dcnt;
   logic          keep;

   assign keep = in_valid && (dcnt == '0);

   // NOTE: sequential state is updated with non-blocking assignments so every
   // register samples the pre-edge values of its neighbours.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)        dcnt <= '0;
      else if (in_valid) dcnt <= (dcnt == DCNT_MAX) ? '0 : dcnt + CW'(1);
   end

   // ---------------- stage 1: round, then shift ----------------
   logic [IN_W:0]  rsum;
   logic [R_W-1:0] s1_data;
   logic           s1_valid;

   // Sign-extend by one bit so adding the half-LSB can never wrap.
   assign rsum = {In1[IN_W-1], In1} + RND;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
      end else begin
         s1_valid <= keep;
         if (keep) s1_data <= rsum[IN_W:SHIFT];
      end
   end

   // ---------------- stage 2: saturate ----------------
   logic [R_W-OUT_W:0] s1_top;
   logic               ovf;
   logic               sat_ev;
   logic [OUT_W-1:0]   sat_val;
   logic [OUT_W-1:0]   s2_data;
   logic               s2_valid;

   // In range only when every bit above the output sign bit matches it.
   assign s1_top  = s1_data[R_W-1:OUT_W-1];
   assign ovf     = !((&s1_top) || !(|s1_top));
   assign sat_ev  = s1_valid && ovf;
   assign sat_val = s1_data[R_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                   : {1'b0, {(OUT_W-1){1'b1}}};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s2_valid <= 1'b0;
         s2_data  <= '0;
      end else begin
         s2_valid <= s1_valid;
         if (s1_valid) s2_data <= ovf ? sat_val : s1_data[OUT_W-1:0];
      end
   end

   // A saturation in the same cycle as a clear wins, restarting the count at 1.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sat_flag  <= 1'b0;
         sat_count <= '0;
      end else if (sat_ev) begin
         sat_flag  <= 1'b1;
         if (clr_stat)                  sat_count <= 16'd1;
         else if (sat_count != 16'hFFFF) sat_count <= sat_count + 16'd1;
      end else if (clr_stat) begin
         sat_flag  <= 1'b0;
         sat_count <= '0;
      end
   end

   // ---------------- output FIFO ----------------
   logic [OUT_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      level;
   logic [OUT_W-1:0] last_out;
   logic             full;
   logic             pop;
   logic             wr_en;
   logic             drop;

   assign full      = (level == FULL_LVL);
   assign out_valid = (level != '0);
   assign fifo_level = level;
   assign Out1      = out_valid ? mem[rd_ptr] : last_out;

   always_comb begin
      // NOTE: defaults first so every path assigns and no latch is inferred.
      pop   = 1'b0;
      wr_en = 1'b0;
      drop  = 1'b0;
      if (out_valid && out_ready) pop = 1'b1;
      if (s2_valid) begin
         if (!full || pop) wr_en = 1'b1;
         else              drop  = 1'b1;
      end
   end

   // NOTE: storage is not reset; it is only observed while level != 0.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= s2_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level      <= '0;
         last_out   <= '0;
         drop_pulse <= 1'b0;
      end else begin
         drop_pulse <= drop;
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (pop) begin
            rd_ptr   <= rd_ptr + AW'(1);
            last_out <= mem[rd_ptr];
         end
         case ({wr_en, pop})
            2'b10:   level <= level + (AW + 1)'(1);
            2'b01:   level <= level - (AW + 1)'(1);
            default: level <= level;
         endcase
      end
   end

endmodule
